instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the main control decoder.
- Owns the PC, issues word requests to instruction memory, and buffers the returned instruction.
- Presents the instruction, its PC and the 7-bit opcode field to decode/control over a valid/ready handshake.
- Accepts a redirect (taken branch, JAL, JALR) from execute and discards any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset (text segment base).
- XLEN, 32, width of PC, address, instruction and counter.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high with stable imem_addr until imem_ack.
- imem_addr  out  XLEN  word address of the fetch (bits [1:0] always 0).
- imem_ack  in  1  response valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  in  XLEN  instruction word; valid when imem_ack=1.
- redirect_valid  in  1  one-cycle pulse, PC redirect from execute.
- redirect_target  in  XLEN  new PC.
- out_valid  out  1  buffered instruction available.
- out_ready  in  1  decode accepts the instruction.
- out_pc  out  XLEN  PC of the buffered instruction.
- out_instr  out  XLEN  buffered instruction.
- out_opc  out  7  out_instr[6:0], fed to the control opcode input.
- misaligned  out  1  one-cycle pulse when redirect_target[1:0] != 0.
- fetch_count  out  XLEN  number of instructions handed off (out_valid & out_ready).

Behaviour:
- Registers: pc, pend_pc, instr_buf, state, fetch_count, misaligned.
- States: FETCH (request outstanding), HOLD (instruction buffered), DRAIN (stale request outstanding; response must be discarded).
- Outputs: imem_req = (state==FETCH || state==DRAIN) && !reset.
  - imem_addr = pc.
  - out_valid = (state==HOLD).
  - out_pc = pc.
  - out_opc = instr_buf[6:0].
- Reset (synchronous): pc=RESET_PC, state=FETCH, instr_buf=0, pend_pc=0, fetch_count=0, misaligned=0.
  - While reset=1, imem_req=0 and out_valid=0.
  - Reset mid-transaction abandons any outstanding request. The memory must tolerate imem_req dropping.
- Target alignment: every redirect_target is masked to {target[XLEN-1:2],2'b00} before use.
  - misaligned<=1 for exactly one cycle after any redirect with target[1:0]!=0; otherwise 0.
- FETCH transitions:
  - redirect_valid & imem_ack: discard rdata; pc<=target; stay FETCH.
  - redirect_valid & !imem_ack: pend_pc<=target; go DRAIN. pc unchanged, so imem_addr stays stable.
  - !redirect_valid & imem_ack: instr_buf<=imem_rdata; go HOLD.
  - Otherwise: stay FETCH.
- HOLD transitions:
  - redirect_valid has priority over out_ready: drop the buffer; pc<=target; go FETCH. No handoff, and fetch_count is unchanged.
  - out_ready: fetch_count<=fetch_count+1 (wraps at 2^XLEN); pc<=pc+4 (wraps modulo 2^XLEN); go FETCH.
  - Otherwise: hold out_pc and out_instr stable.
- DRAIN transitions:
  - imem_req stays high at the old pc.
  - A new redirect_valid overwrites pend_pc (latest wins). This holds even in the cycle of imem_ack.
  - On imem_ack: discard rdata; pc<=pend_pc (or the same-cycle target); go FETCH.
- Latency and throughput:
  - Zero-wait memory: request in cycle N, out_valid in N+1.
  - Peak throughput is one instruction per 2 cycles.
  - Redirect to first new request: next cycle from FETCH-with-ack or HOLD; after the stale ack from FETCH-without-ack or DRAIN.
- Handshake rule: once out_valid=1, out_pc and out_instr must not change until the handoff or a redirect.

Test Plan:
- Reset release, zero-wait memory returning 32'h00000013 (nop): imem_addr=0x00400000 in cycle 0, out_valid cycle 1, out_opc=7'h13, out_ready=1 → next imem_addr=0x00400004, fetch_count=1.
- Back-pressure: out_ready=0 for 5 cycles in HOLD → out_pc/out_instr constant, imem_req=0, fetch_count unchanged; then out_ready=1 → single increment.
- Redirect during HOLD together with out_ready=1, target 0x00400100 → instruction dropped, fetch_count unchanged, next imem_addr=0x00400100.
- Redirect in FETCH with 3-wait-state memory, target 0x00400200, then second redirect 0x00400300 in DRAIN → imem_addr stays old pc until ack, stale rdata never appears on out_instr, next request at 0x00400300.
- Misaligned redirect target 0x00400102 → misaligned pulses 1 cycle, fetch at 0x00400100.
- Reset asserted while in DRAIN → next cycle imem_req=0, out_valid=0; after release fetch at 0x00400000, fetch_count=0.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage that feeds the main control decoder. It owns the
//   PC, issues word requests to instruction memory, buffers one returned
//   instruction and presents it to decode over a valid/ready handshake.
//   Redirects from execute (taken branch, JAL, JALR) replace the PC. When a
//   redirect arrives while a fetch is still outstanding, that fetch becomes
//   stale and its response is discarded.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   imem_req         fetch request, held with stable imem_addr until imem_ack
//   imem_addr        word address of the fetch (bits [1:0] always zero)
//   imem_ack         response valid this cycle (may coincide with imem_req)
//   imem_rdata       instruction word, valid with imem_ack
//   redirect_valid   one-cycle redirect pulse from execute
//   redirect_target  new PC (low two bits are masked off)
//   out_valid        buffered instruction available to decode
//   out_ready        decode accepts the buffered instruction
//   out_pc           PC of the buffered instruction
//   out_instr        buffered instruction
//   out_opc          out_instr[6:0], drives the control opcode input
//   misaligned       one-cycle pulse after a redirect with target[1:0] != 0
//   fetch_count      number of instructions handed off to decode
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [6:0]      out_opc,
    output logic            misaligned,
    output logic [XLEN-1:0] fetch_count
);

    // FETCH: request outstanding and its response is wanted.
    // HOLD : instruction buffered, waiting for decode.
    // DRAIN: request outstanding but stale; the response is dropped.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_pc_q;
    logic [XLEN-1:0] instr_buf_q;
    logic [XLEN-1:0] fetch_count_q;
    logic            misaligned_q;

    // Redirect target forced onto a word boundary before any use.
    logic [XLEN-1:0] redirect_pc;
    assign redirect_pc = {redirect_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            instr_buf_q   <= '0;
            fetch_count_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            misaligned_q <= redirect_valid && (redirect_target[1:0] != 2'b00);

            unique case (state_q)
                FETCH: begin
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            // Response belongs to the old path: drop it and
                            // start the new fetch right away.
                            pc_q <= redirect_pc;
                        end else begin
                            // Keep imem_addr stable until the old request is
                            // acknowledged; remember where to go afterwards.
                            pend_pc_q <= redirect_pc;
                            state_q   <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        instr_buf_q <= imem_rdata;
                        state_q     <= HOLD;
                    end
                end

                HOLD: begin
                    // A redirect squashes the buffered instruction even if
                    // decode is ready to take it in the same cycle.
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= FETCH;
                    end else if (out_ready) begin
                        fetch_count_q <= fetch_count_q + XLEN'(1);
                        pc_q          <= pc_q + XLEN'(4);
                        state_q       <= FETCH;
                    end
                end

                DRAIN: begin
                    if (imem_ack) begin
                        // Latest redirect wins, including one arriving in the
                        // same cycle as the stale acknowledge.
                        pc_q    <= redirect_valid ? redirect_pc : pend_pc_q;
                        state_q <= FETCH;
                    end else if (redirect_valid) begin
                        pend_pc_q <= redirect_pc;
                    end
                end

                default: state_q <= FETCH;
            endcase
        end
    end

    // Reset gates the handshake outputs combinationally so neither side sees
    // activity during the reset cycle itself.
    assign imem_req    = ((state_q == FETCH) || (state_q == DRAIN)) && !reset;
    assign imem_addr   = pc_q;
    assign out_valid   = (state_q == HOLD) && !reset;
    assign out_pc      = pc_q;
    assign out_instr   = instr_buf_q;
    assign out_opc     = instr_buf_q[6:0];
    assign misaligned  = misaligned_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A memory responder with a programmable
//   number of wait states answers fetches; a behavioural model tracks what the
//   fetch stage must present and is compared against the DUT every cycle,
//   alongside hand-computed literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_opc;
    logic        misaligned;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    // Memory responder configuration
    int ws       = 0;     // wait states before acknowledging
    bit nop_mode = 1'b1;  // return nop for every address
    int mem_cnt  = 0;

    instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_opc         (out_opc),
        .misaligned      (misaligned),
        .fetch_count     (fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return nop_mode ? 32'h0000_0013 : (a ^ 32'h5A5A_0033);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            nxt();
            n++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    // Memory: acknowledges after ws cycles of continuous request, evaluated
    // just after the falling edge so the stimulus for the cycle is settled.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clock);
            #1;
            if (!imem_req) begin
                mem_cnt  = 0;
                imem_ack = 1'b0;
            end else if (mem_cnt >= ws) begin
                imem_ack = 1'b1;
                mem_cnt  = 0;
            end else begin
                imem_ack = 1'b0;
                mem_cnt++;
            end
            imem_rdata = imem_ack ? memfn(imem_addr) : 32'hDEAD_BEEF;
        end
    end

    // Behavioural model: either an instruction is buffered (m_have) or a
    // request is outstanding, which may be stale (m_stale) with a pending
    // destination m_nxt.
    bit          model_ok = 1'b0;
    bit          m_have, m_stale, m_mis;
    logic [31:0] m_pc, m_nxt, m_buf, m_cnt, m_tgt;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_pc = RESET_PC; m_nxt = '0; m_buf = '0; m_cnt = '0;
                m_have = 1'b0; m_stale = 1'b0; m_mis = 1'b0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                m_tgt = redirect_target & 32'hFFFF_FFFC;
                m_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
                if (m_have) begin
                    if (redirect_valid) begin
                        m_have = 1'b0;
                        m_pc   = m_tgt;
                    end else if (out_ready) begin
                        m_cnt  = m_cnt + 1;
                        m_pc   = m_pc + 4;
                        m_have = 1'b0;
                    end
                end else if (imem_ack) begin
                    if (redirect_valid) begin
                        m_pc    = m_tgt;
                        m_stale = 1'b0;
                    end else if (m_stale) begin
                        m_pc    = m_nxt;
                        m_stale = 1'b0;
                    end else begin
                        m_buf  = imem_rdata;
                        m_have = 1'b1;
                    end
                end else if (redirect_valid) begin
                    m_stale = 1'b1;
                    m_nxt   = m_tgt;
                end
            end
            #1;
            if (model_ok) begin
                chk("sb_req",   32'(imem_req),  32'(!m_have && !reset));
                chk("sb_addr",  imem_addr,      m_pc);
                chk("sb_valid", 32'(out_valid), 32'(m_have && !reset));
                chk("sb_pc",    out_pc,         m_pc);
                chk("sb_instr", out_instr,      m_buf);
                chk("sb_opc",   32'(out_opc),   32'(m_buf[6:0]));
                chk("sb_mis",   32'(misaligned), 32'(m_mis));
                chk("sb_count", fetch_count,    m_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready       = 1'b0;
        repeat (3) nxt();

        // Reset state
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", fetch_count,    32'd0);
        chk("rst_addr",  imem_addr,      32'h0040_0000);

        // Zero-wait nop fetch and handoff
        reset = 1'b0;
        #1;
        chk("t1_req",   32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr,     32'h0040_0000);
        nxt();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_opc",   32'(out_opc),   32'h13);
        chk("t1_pc",    out_pc,         32'h0040_0000);
        out_ready = 1'b1;
        nxt();
        out_ready = 1'b0;
        chk("t1_addr1", imem_addr,   32'h0040_0004);
        chk("t1_count", fetch_count, 32'd1);

        // Back-pressure in HOLD for five cycles
        nxt();
        repeat (5) begin
            chk("t2_pc",    out_pc,        32'h0040_0004);
            chk("t2_instr", out_instr,     32'h0000_0013);
            chk("t2_req",   32'(imem_req), 32'd0);
            chk("t2_count", fetch_count,   32'd1);
            nxt();
        end
        out_ready = 1'b1;
        nxt();
        out_ready = 1'b0;
        chk("t2_count2", fetch_count,    32'd2);
        chk("t2_valid",  32'(out_valid), 32'd0);
        nxt();
        nop_mode = 1'b0;

        // Redirect in HOLD wins over out_ready
        chk("t3_valid0", 32'(out_valid), 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0100;
        out_ready       = 1'b1;
        nxt();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        ws             = 3;
        chk("t3_addr",  imem_addr,      32'h0040_0100);
        chk("t3_count", fetch_count,    32'd2);
        chk("t3_valid", 32'(out_valid), 32'd0);

        // Redirect while waiting, then a second redirect while draining
        nxt();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0200;
        nxt();
        redirect_target = 32'h0040_0300;
        chk("t4_addr_a", imem_addr,      32'h0040_0100);
        chk("t4_req",    32'(imem_req),  32'd1);
        chk("t4_valid",  32'(out_valid), 32'd0);
        nxt();
        redirect_valid = 1'b0;
        chk("t4_addr_b",  imem_addr,      32'h0040_0100);
        chk("t4_valid_b", 32'(out_valid), 32'd0);
        nxt();
        chk("t4_addr_new", imem_addr,      32'h0040_0300);
        chk("t4_valid_c",  32'(out_valid), 32'd0);
        wait_valid("t4_wait");
        chk("t4_pc",    out_pc,    32'h0040_0300);
        chk("t4_instr", out_instr, 32'h5A1A_0333);

        // Misaligned redirect target
        ws              = 0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0102;
        nxt();
        redirect_valid = 1'b0;
        chk("t5_mis1",  32'(misaligned), 32'd1);
        chk("t5_addr",  imem_addr,       32'h0040_0100);
        chk("t5_valid", 32'(out_valid),  32'd0);
        nxt();
        chk("t5_mis0",   32'(misaligned), 32'd0);
        chk("t5_valid1", 32'(out_valid),  32'd1);
        chk("t5_pc",     out_pc,          32'h0040_0100);

        // Reset while draining a stale request
        ws        = 3;
        out_ready = 1'b1;
        nxt();
        out_ready = 1'b0;
        chk("t6_count3", fetch_count, 32'd3);
        nxt();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0400;
        nxt();
        redirect_valid = 1'b0;
        chk("t6_req_drain",  32'(imem_req),  32'd1);
        chk("t6_addr_drain", imem_addr,      32'h0040_0104);
        chk("t6_valid",      32'(out_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("t6_req_rst", 32'(imem_req), 32'd0);
        nxt();
        chk("t6_req_after",   32'(imem_req),  32'd0);
        chk("t6_valid_after", 32'(out_valid), 32'd0);
        chk("t6_count0",      fetch_count,    32'd0);
        nxt();

        // Release with a redirect coinciding with a zero-wait ack
        ws              = 0;
        reset           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0500;
        #1;
        chk("t7_addr0", imem_addr,     32'h0040_0000);
        chk("t7_req",   32'(imem_req), 32'd1);
        chk("t7_count", fetch_count,   32'd0);
        nxt();
        redirect_valid = 1'b0;
        ws             = 2;
        chk("t7_addr1", imem_addr,      32'h0040_0500);
        chk("t7_valid", 32'(out_valid), 32'd0);

        // Redirect in DRAIN coinciding with the stale ack
        nxt();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0600;
        nxt();
        redirect_target = 32'h0040_0700;
        nxt();
        redirect_valid = 1'b0;
        chk("t8_addr",  imem_addr,      32'h0040_0700);
        chk("t8_valid", 32'(out_valid), 32'd0);
        wait_valid("t8_wait");
        chk("t8_pc",    out_pc,    32'h0040_0700);
        chk("t8_instr", out_instr, 32'h5A1A_0733);
        out_ready = 1'b1;
        nxt();
        out_ready = 1'b0;
        chk("t8_count", fetch_count, 32'd1);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
